bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the four-digit multiplexed seven-segment display stage. It turns a binary count or measurement into the ones/tens/hundreds/thousands nibbles that stage selects and decodes.
- Uses a start/busy/done handshake and holds the last result stable between conversions.

---
 rtl/bin_to_bcd_seq.sv | 156 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Result and overflow flag are held stable between conversions.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CAT_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0]      MAX_VAL   = pow10(DIGITS) - 64'd1;
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_done;

    logic [BIN_W-1:0]   w_shift_nxt;
    logic [BCD_W-1:0]   w_scratch_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf_pend_nxt;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               w_ovf_nxt;
    logic               w_done_nxt;

    logic [BCD_W-1:0]   w_adj;
    logic [CAT_W-1:0]   w_cat;
    logic               w_last;
    logic               w_in_ovf;

    // Add 3 to every scratch digit that is 5 or more before the shift
    always_comb begin
        w_adj = r_scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // Shifted {scratch, input}; last-bit and input-overflow detection
    always_comb begin
        w_cat    = {w_adj, r_shift} << 1;
        w_last   = (r_state == S_SHIFT) && (r_cnt == CNT_W'(1));
        w_in_ovf = (64'(bin) > MAX_VAL);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values per state
    always_comb begin
        w_shift_nxt    = r_shift;
        w_scratch_nxt  = r_scratch;
        w_cnt_nxt      = r_cnt;
        w_ovf_pend_nxt = r_ovf_pend;
        w_bcd_nxt      = r_bcd;
        w_ovf_nxt      = r_ovf;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shift_nxt    = bin;
                    w_scratch_nxt  = '0;
                    w_cnt_nxt      = CNT_W'(BIN_W);
                    w_ovf_pend_nxt = w_in_ovf;
                end
            end
            S_SHIFT: begin
                w_shift_nxt   = w_cat[BIN_W-1:0];
                w_scratch_nxt = w_cat[CAT_W-1:BIN_W];
                w_cnt_nxt     = r_cnt - CNT_W'(1);
                if (w_last) begin
                    w_bcd_nxt  = r_ovf_pend ? ALL_NINES : w_cat[CAT_W-1:BIN_W];
                    w_ovf_nxt  = r_ovf_pend;
                    w_done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_scratch  <= w_scratch_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf_pend <= w_ovf_pend_nxt;
            r_bcd      <= w_bcd_nxt;
            r_ovf      <= w_ovf_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: default (14-bit, 4-digit) and narrow (8-bit, 2-digit) instances.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_w, busy_w, done_w, ovf_w;
    logic [13:0] bin_w;
    logic [15:0] bcd_w;

    logic        start_n, busy_n, done_n, ovf_n;
    logic [7:0]  bin_n;
    logic [7:0]  bcd_n;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start_w), .bin(bin_w),
        .busy(busy_w), .done(done_w), .bcd(bcd_w), .ovf(ovf_w)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_n), .bin(bin_n),
        .busy(busy_n), .done(done_n), .bcd(bcd_n), .ovf(ovf_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v, or all nines when v does not fit in nd digits
    function automatic void ref_model(input int unsigned v, input int unsigned nd,
                                      output logic [31:0] b, output logic o);
        int unsigned lim;
        int unsigned p;
        lim = 1;
        for (int unsigned i = 0; i < nd; i++) lim = lim * 10;
        o = (v > lim - 1);
        b = '0;
        p = 1;
        for (int unsigned i = 0; i < nd; i++) begin
            b[4*i +: 4] = o ? 4'd9 : 4'((v / p) % 10);
            p = p * 10;
        end
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? done_n : done_w;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy_n : busy_w;
    endfunction

    // Starts a conversion at the current negedge and checks result, latency and busy time
    task automatic conv(input bit sel, input int unsigned v);
        logic [31:0] exp_bcd;
        logic        exp_ovf;
        int unsigned k;
        int unsigned nb;
        int unsigned lat;
        string       t;
        lat = sel ? 8 : 14;
        ref_model(v, sel ? 2 : 4, exp_bcd, exp_ovf);
        t = $sformatf("%s v=%0d", sel ? "n8" : "w14", v);
        if (sel) begin start_n = 1'b1; bin_n = 8'(v); end
        else     begin start_w = 1'b1; bin_w = 14'(v); end
        @(negedge clk);
        if (sel) begin start_n = 1'b0; bin_n = 8'($urandom); end
        else     begin start_w = 1'b0; bin_w = 14'($urandom); end
        k  = 1;
        nb = 0;
        while (!get_done(sel) && k < 40) begin
            if (get_busy(sel)) nb++;
            @(negedge clk);
            k++;
        end
        check({t, " latency"}, 32'(k - 1), 32'(lat));
        check({t, " busy_cycles"}, 32'(nb), 32'(lat));
        check({t, " busy_at_done"}, 32'(get_busy(sel)), 32'd0);
        check({t, " bcd"}, sel ? 32'(bcd_n) : 32'(bcd_w), exp_bcd);
        check({t, " ovf"}, sel ? 32'(ovf_n) : 32'(ovf_w), 32'(exp_ovf));
    endtask

    initial begin
        int unsigned dir_vals[15];
        int unsigned kd;
        int unsigned nd;
        dir_vals = '{0, 1234, 9999, 7, 5, 10000, 16383, 42, 1, 9, 10, 99, 100, 999, 1000};

        rst = 1'b1;
        start_w = 1'b0; bin_w = '0;
        start_n = 1'b0; bin_n = '0;
        #12;
        check("reset bcd", 32'(bcd_w), 32'd0);
        check("reset busy", 32'(busy_w), 32'd0);
        check("reset done", 32'(done_w), 32'd0);
        check("reset ovf", 32'(ovf_w), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed values including overflow boundaries
        foreach (dir_vals[i]) begin
            conv(1'b0, dir_vals[i]);
            @(negedge clk);
        end

        // Random values, some clustered around the overflow limit
        for (int i = 0; i < 250; i++) begin
            if (i % 5 == 0) conv(1'b0, $urandom_range(9990, 10010));
            else            conv(1'b0, $urandom_range(0, 16383));
            @(negedge clk);
        end

        // Start pulses while busy must be ignored
        start_w = 1'b1; bin_w = 14'd321;
        kd = 0;
        for (int unsigned k = 1; k < 40; k++) begin
            @(negedge clk);
            if (done_w) begin kd = k; break; end
            start_w = (k == 3 || k == 13);
            bin_w   = start_w ? 14'd888 : 14'($urandom);
        end
        check("ignore_busy latency", 32'(kd - 1), 32'd14);
        check("ignore_busy bcd", 32'(bcd_w), 32'h0321);
        // Back-to-back start in the done cycle
        conv(1'b0, 4095);
        @(negedge clk);
        check("done single pulse", 32'(done_w), 32'd0);
        check("no queued start", 32'(busy_w), 32'd0);

        // Reset mid-conversion after an overflowing result
        conv(1'b0, 10000);
        @(negedge clk);
        start_w = 1'b1; bin_w = 14'd5678;
        @(negedge clk);
        start_w = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst bcd", 32'(bcd_w), 32'd0);
        check("midrst ovf", 32'(ovf_w), 32'd0);
        check("midrst busy", 32'(busy_w), 32'd0);
        check("midrst done", 32'(done_w), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_w || busy_w) nd++;
        end
        check("midrst idle_after", 32'(nd), 32'd0);
        check("midrst bcd_hold", 32'(bcd_w), 32'd0);

        // Narrow configuration: exhaustive sweep
        for (int unsigned v = 0; v < 256; v++) begin
            conv(1'b1, v);
            @(negedge clk);
        end
        conv(1'b1, 255);
        @(negedge clk);
        conv(1'b1, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
